// File: rtl/fetch_sequencer_if.sv
// Nibbler fetch-sequencer bus: ROM read port plus the execute-side controls.
// The master modport belongs to the sequencer; the slave modport belongs to the ROM/execute side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              run;
    logic              stall;
    logic              loadPC;
    logic [ADDR_W-1:0] pcTarget;
    logic [DATA_W-1:0] romData;
    logic [ADDR_W-1:0] romAddress;
    logic              romNotCe;
    logic              romNotOe;
    logic              romNotWe;
    logic [3:0]        instruction;
    logic [3:0]        operand;
    logic              ph;
    logic              instrValid;
    logic [ADDR_W-1:0] pc;

    modport master (
        input  run, stall, loadPC, pcTarget, romData,
        output romAddress, romNotCe, romNotOe, romNotWe,
        output instruction, operand, ph, instrValid, pc
    );

    modport slave (
        output run, stall, loadPC, pcTarget, romData,
        input  romAddress, romNotCe, romNotOe, romNotWe,
        input  instruction, operand, ph, instrValid, pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Nibbler program-ROM sequencer: owns the PC, runs the ROM read cycle and
// splits each fetched byte into instruction/operand nibbles for the execute phase.
module fetch_sequencer #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int ROM_LATENCY  = 1,
    parameter int RESET_VECTOR = 0
) (
    input logic               clk,
    input logic               notReset,
    fetch_sequencer_if.master bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] FETCH = 2'b01;
    localparam logic [1:0] EXEC  = 2'b10;

    localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ROM_LATENCY - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  waitCnt;
    logic [ADDR_W-1:0] pcReg;
    logic [3:0]        instrReg;
    logic [3:0]        operReg;
    logic              validReg;

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state    <= IDLE;
            waitCnt  <= '0;
            pcReg    <= ADDR_W'(RESET_VECTOR);
            instrReg <= '0;
            operReg  <= '0;
            validReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        state   <= FETCH;
                        waitCnt <= '0;
                    end
                end
                FETCH: begin
                    if (waitCnt == LAST_WAIT) begin
                        instrReg <= bus.romData[DATA_W-1 -: 4];
                        operReg  <= bus.romData[3:0];
                        pcReg    <= pcReg + ADDR_W'(1);
                        validReg <= 1'b1;
                        waitCnt  <= '0;
                        state    <= EXEC;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                EXEC: begin
                    validReg <= 1'b0;
                    if (!bus.stall) begin
                        // A jump target replaces the increment already applied at capture.
                        if (bus.loadPC) pcReg <= bus.pcTarget;
                        waitCnt <= '0;
                        state   <= bus.run ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state so an async reset releases the ROM at once.
    assign bus.romAddress  = pcReg;
    assign bus.romNotCe    = (state != FETCH);
    assign bus.romNotOe    = (state != FETCH);
    assign bus.romNotWe    = 1'b1;
    assign bus.instruction = instrReg;
    assign bus.operand     = operReg;
    assign bus.ph          = (state == EXEC);
    assign bus.instrValid  = validReg;
    assign bus.pc          = pcReg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a cycle model checked every negedge on two
// instances (ROM latency 1 and 3), plus directed vectors with literal expectations.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic notReset;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(12), .DATA_W(8)) bus1 ();
    fetch_sequencer_if #(.ADDR_W(12), .DATA_W(8)) bus3 ();

    fetch_sequencer #(.ADDR_W(12), .DATA_W(8), .ROM_LATENCY(1), .RESET_VECTOR(0))
        dut1 (.clk(clk), .notReset(notReset), .bus(bus1));
    fetch_sequencer #(.ADDR_W(12), .DATA_W(8), .ROM_LATENCY(3), .RESET_VECTOR(0))
        dut3 (.clk(clk), .notReset(notReset), .bus(bus3));

    logic [7:0] rom1 [0:4095];
    assign bus1.romData = rom1[bus1.romAddress];

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: fetchLeft counts remaining read cycles; inExec marks the execute phase.
    typedef struct {
        int         fetchLeft;
        bit         inExec;
        bit         first;
        logic [11:0] pc;
        logic [3:0] ins;
        logic [3:0] opr;
    } model_t;

    function automatic model_t modelReset();
        model_t m;
        m.fetchLeft = 0; m.inExec = 0; m.first = 0;
        m.pc = 12'h000; m.ins = 4'h0; m.opr = 4'h0;
        return m;
    endfunction

    function automatic model_t modelStep(input model_t m, input int lat, input bit run,
                                         input bit stall, input bit ld, input logic [11:0] tgt,
                                         input logic [7:0] data);
        model_t n = m;
        n.first = 0;
        if (m.fetchLeft > 0) begin
            if (m.fetchLeft == 1) begin
                n.ins = data[7:4];
                n.opr = data[3:0];
                n.pc = 12'((int'(m.pc) + 1) % 4096);
                n.fetchLeft = 0;
                n.inExec = 1;
                n.first = 1;
            end else begin
                n.fetchLeft = m.fetchLeft - 1;
            end
        end else if (m.inExec) begin
            if (!stall) begin
                if (ld) n.pc = tgt;
                n.inExec = 0;
                n.fetchLeft = run ? lat : 0;
            end
        end else if (run) begin
            n.fetchLeft = lat;
        end
        return n;
    endfunction

    model_t m1, m3;

    always @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            m1 <= modelReset();
            m3 <= modelReset();
        end else begin
            m1 <= modelStep(m1, 1, bus1.run, bus1.stall, bus1.loadPC, bus1.pcTarget, bus1.romData);
            m3 <= modelStep(m3, 3, bus3.run, bus3.stall, bus3.loadPC, bus3.pcTarget, bus3.romData);
        end
    end

    task automatic cmpDut(input string tag, input model_t m, input logic [11:0] addr,
                          input logic [11:0] pcv, input logic ce, input logic oe, input logic we,
                          input logic phv, input logic iv, input logic [3:0] ins, input logic [3:0] opr);
        chk({tag, ".romAddress"}, addr, m.pc);
        chk({tag, ".pc"}, pcv, m.pc);
        chk({tag, ".romNotCe"}, ce, (m.fetchLeft > 0) ? 0 : 1);
        chk({tag, ".romNotOe"}, oe, (m.fetchLeft > 0) ? 0 : 1);
        chk({tag, ".romNotWe"}, we, 1);
        chk({tag, ".ph"}, phv, m.inExec);
        chk({tag, ".instrValid"}, iv, m.first);
        chk({tag, ".instruction"}, ins, m.ins);
        chk({tag, ".operand"}, opr, m.opr);
    endtask

    always @(negedge clk) begin
        if (notReset === 1'b1) begin
            cmpDut("m1", m1, bus1.romAddress, bus1.pc, bus1.romNotCe, bus1.romNotOe, bus1.romNotWe,
                   bus1.ph, bus1.instrValid, bus1.instruction, bus1.operand);
            cmpDut("m3", m3, bus3.romAddress, bus3.pc, bus3.romNotCe, bus3.romNotOe, bus3.romNotWe,
                   bus3.ph, bus3.instrValid, bus3.instruction, bus3.operand);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom1[i] = 8'((i * 7) + 3);
        rom1[0] = 8'h3A; rom1[1] = 8'h51; rom1[2] = 8'hC7;
        rom1[12'h7F0] = 8'hE4; rom1[12'hFFF] = 8'h6B;

        notReset = 1'b0;
        bus1.run = 0; bus1.stall = 0; bus1.loadPC = 0; bus1.pcTarget = '0;
        bus3.run = 0; bus3.stall = 0; bus3.loadPC = 0; bus3.pcTarget = '0; bus3.romData = '0;

        #3;
        chk("rst.pc", bus1.pc, 12'h000);
        chk("rst.romAddress", bus1.romAddress, 12'h000);
        chk("rst.romNotCe", bus1.romNotCe, 1);
        chk("rst.romNotOe", bus1.romNotOe, 1);
        chk("rst.romNotWe", bus1.romNotWe, 1);
        chk("rst.instr", {bus1.instruction, bus1.operand}, 8'h00);
        chk("rst.ph", bus1.ph, 0);
        chk("rst.instrValid", bus1.instrValid, 0);

        tick(); notReset = 1'b1;
        tick(); bus1.run = 1;

        // Straight-line fetch of ROM[0..2]
        tick(); chk("t1.fetch0.ce", bus1.romNotCe, 0); chk("t1.fetch0.addr", bus1.romAddress, 12'h000);
        tick(); chk("t1.exec0", {bus1.instruction, bus1.operand}, 8'h3A);
                chk("t1.exec0.pc", bus1.pc, 12'h001); chk("t1.exec0.iv", bus1.instrValid, 1);
        tick(); chk("t1.fetch1.addr", bus1.romAddress, 12'h001);
        tick(); chk("t1.exec1", {bus1.instruction, bus1.operand}, 8'h51); chk("t1.exec1.pc", bus1.pc, 12'h002);
        tick();
        tick(); chk("t1.exec2", {bus1.instruction, bus1.operand}, 8'hC7); chk("t1.exec2.pc", bus1.pc, 12'h003);
        bus1.loadPC = 1; bus1.pcTarget = 12'h000;

        // Stall the execute of ROM[0]; a jump presented while stalled must be ignored
        tick(); chk("t2.jump0.addr", bus1.romAddress, 12'h000); bus1.loadPC = 0;
        tick(); chk("t2.exec.iv", bus1.instrValid, 1);
        bus1.stall = 1; bus1.loadPC = 1; bus1.pcTarget = 12'h555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2.stall.ph", bus1.ph, 1);
            chk("t2.stall.iv", bus1.instrValid, 0);
            chk("t2.stall.ce", bus1.romNotCe, 1);
            chk("t2.stall.oe", bus1.romNotOe, 1);
            chk("t2.stall.pc", bus1.pc, 12'h001);
        end
        bus1.stall = 0; bus1.pcTarget = 12'h7F0;

        tick(); chk("t3.fetch.addr", bus1.romAddress, 12'h7F0); chk("t3.fetch.ph", bus1.ph, 0);
        bus1.loadPC = 1; bus1.pcTarget = 12'h123;
        tick(); chk("t3.exec.pc", bus1.pc, 12'h7F1); chk("t3.exec", {bus1.instruction, bus1.operand}, 8'hE4);
        bus1.loadPC = 1; bus1.pcTarget = 12'hFFF;

        // Wrap past the top of the address space
        tick(); chk("t4.fetch.addr", bus1.romAddress, 12'hFFF); bus1.loadPC = 0;
        tick(); chk("t4.wrap.pc", bus1.pc, 12'h000); chk("t4.wrap.addr", bus1.romAddress, 12'h000);
                chk("t4.exec", {bus1.instruction, bus1.operand}, 8'h6B);
        bus1.loadPC = 1; bus1.pcTarget = 12'h000;

        // Self-loop jump, then drop run mid-fetch
        tick(); chk("t6.selfloop.addr", bus1.romAddress, 12'h000); bus1.loadPC = 0; bus1.run = 0;
        tick(); chk("t6.exec", {bus1.instruction, bus1.operand}, 8'h3A); chk("t6.exec.iv", bus1.instrValid, 1);
        tick(); chk("t6.idle.ce", bus1.romNotCe, 1); chk("t6.idle.ph", bus1.ph, 0); chk("t6.idle.pc", bus1.pc, 12'h001);
        tick(); chk("t6.idle2.oe", bus1.romNotOe, 1);

        // Latency-3 instance: only the byte present at the third edge is captured
        bus3.run = 1;
        tick(); chk("t5.c1.ce", bus3.romNotCe, 0); bus3.run = 0; bus3.romData = 8'h11;
        tick(); chk("t5.c2.ce", bus3.romNotCe, 0); bus3.romData = 8'h22;
        tick(); chk("t5.c3.ce", bus3.romNotCe, 0); chk("t5.c3.oe", bus3.romNotOe, 0); bus3.romData = 8'h9E;
        tick(); chk("t5.exec.ce", bus3.romNotCe, 1); chk("t5.exec", {bus3.instruction, bus3.operand}, 8'h9E);
                chk("t5.exec.pc", bus3.pc, 12'h001); chk("t5.exec.iv", bus3.instrValid, 1);
        tick(); chk("t5.idle.ph", bus3.ph, 0);

        // Async reset in the middle of a fetch
        bus1.run = 1;
        tick(); chk("t6.refetch.ce", bus1.romNotCe, 0); chk("t6.refetch.addr", bus1.romAddress, 12'h001);
        #1 notReset = 1'b0;
        #1;
        chk("t6.arst.ce", bus1.romNotCe, 1);
        chk("t6.arst.oe", bus1.romNotOe, 1);
        chk("t6.arst.pc", bus1.pc, 12'h000);
        chk("t6.arst.addr", bus1.romAddress, 12'h000);
        chk("t6.arst.instr", {bus1.instruction, bus1.operand}, 8'h00);
        chk("t6.arst.ph", bus1.ph, 0);
        chk("t6.arst.iv", bus1.instrValid, 0);
        tick(); chk("t6.held.pc", bus1.pc, 12'h000); chk("t6.held.ce", bus1.romNotCe, 1);
        notReset = 1'b1;
        tick(); chk("t6.restart.ce", bus1.romNotCe, 0);
        tick(); chk("t6.restart", {bus1.instruction, bus1.operand}, 8'h3A); chk("t6.restart.pc", bus1.pc, 12'h001);
        bus1.run = 0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
